// File: rtl/rv32i_types.sv
// rv32i_types: shared arbiter defaults and the arbiter FSM state type
package rv32i_types;
  localparam int NUM_PORTS_DEF = 2;
  localparam int BURST_LEN_DEF = 4;
  typedef enum logic {IDLE, WBURST} arb_state_t;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: synchronous tag FIFO; i_push/i_pop/i_din in, o_dout (head)/o_full/o_empty out
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_dout = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp <= inc(r_wp);
      end
      if (w_pop) r_rp <= inc(r_rp);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NUM_PORTS req_* ports arbitrated (RR or fixed) onto one bmem_* channel; write bursts lock the port, read beats routed by tag FIFO
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0][31:0]  req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS-1:0][63:0]  req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [NUM_PORTS-1:0]        req_rvalid,
  output logic [NUM_PORTS-1:0]        req_wdone,
  output logic [31:0]                 bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [63:0]                 bmem_wdata,
  input  logic                        bmem_ready,
  input  logic                        bmem_rvalid
);
  localparam int TW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(BURST_LEN + 1);
  arb_state_t r_state;
  logic [TW-1:0] r_ptr, r_lock, w_gnt, w_head, w_nxt, w_base, w_k;
  logic [CW-1:0] r_wcnt, r_rcnt;
  logic [NUM_PORTS-1:0] r_wdone, w_elig;
  logic w_gnt_v, w_wr, w_fire, w_full, w_empty, w_push, w_pop, w_rbeat, r_err_underflow;
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      w_elig[p] = (r_state == IDLE) ? (req_write[p] || (req_read[p] && !w_full))
                                    : (req_write[p] && TW'(p) == r_lock);
  end
  assign w_base = FIXED_PRIO != 0 ? '0 : r_ptr;
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt = '0;
    w_k = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_k = TW'((int'(w_base) + i) % NUM_PORTS);
      if (w_elig[w_k]) begin
        w_gnt_v = 1'b1;
        w_gnt = w_k;
      end
    end
  end
  assign w_wr = (r_state == WBURST) || req_write[w_gnt];
  assign w_fire = w_gnt_v && bmem_ready && !rst;
  assign w_nxt = (w_gnt == TW'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
  assign req_ready = w_fire ? NUM_PORTS'(1) << w_gnt : '0;
  assign bmem_addr = (w_gnt_v && !rst) ? req_addr[w_gnt] : '0;
  assign bmem_write = w_gnt_v && !rst && w_wr;
  assign bmem_read = w_gnt_v && !rst && !w_wr;
  assign bmem_wdata = bmem_write ? req_wdata[w_gnt] : '0;
  assign w_push = w_fire && !w_wr;
  assign w_rbeat = bmem_rvalid && !w_empty && !rst;
  assign w_pop = w_rbeat && r_rcnt == CW'(BURST_LEN - 1);
  assign req_rvalid = w_rbeat ? NUM_PORTS'(1) << w_head : '0;
  assign req_wdone = rst ? '0 : r_wdone;
  arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_gnt),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_lock <= '0;
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_wdone <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_wdone <= '0;
      if (w_rbeat) r_rcnt <= w_pop ? '0 : r_rcnt + 1'b1;
      if (bmem_rvalid && w_empty) r_err_underflow <= 1'b1;
      if (w_push) r_ptr <= w_nxt;
      if (w_fire && w_wr) begin
        r_lock <= w_gnt;
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == CW'(BURST_LEN - 1)) begin
          r_state <= IDLE;
          r_wcnt <= '0;
          r_wdone <= NUM_PORTS'(1) << w_gnt;
          r_ptr <= w_nxt;
        end else r_state <= WBURST;
      end
    end
  end
  ap_no_underflow: assert property (@(posedge clk) disable iff (rst) !r_err_underflow);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a queue-based reference model
module tb_mem_port_arbiter;
  localparam int N = 2, BL = 4, MO = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0] req_read, req_write;
  logic [N-1:0][63:0] req_wdata;
  logic [N-1:0] req_ready, req_rvalid, req_wdone;
  logic [31:0] bmem_addr;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0] bmem_wdata;
  logic [N-1:0] fp_ready, fp_rvalid, fp_wdone;
  logic [31:0] fp_addr;
  logic fp_read, fp_write;
  logic [63:0] fp_wdata;
  mem_port_arbiter #(.NUM_PORTS(N), .BURST_LEN(BL), .MAX_OUTSTANDING(MO), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rvalid(req_rvalid), .req_wdone(req_wdone),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid)
  );
  mem_port_arbiter #(.NUM_PORTS(N), .BURST_LEN(BL), .MAX_OUTSTANDING(MO), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_read({N{1'b1}}), .req_write({N{1'b0}}),
    .req_wdata(req_wdata), .req_ready(fp_ready), .req_rvalid(fp_rvalid), .req_wdone(fp_wdone),
    .bmem_addr(fp_addr), .bmem_read(fp_read), .bmem_write(fp_write), .bmem_wdata(fp_wdata),
    .bmem_ready(1'b1), .bmem_rvalid(1'b0)
  );
  typedef struct { int port; logic [31:0] addr; logic [63:0] data; bit wr; } beat_t;
  typedef struct { int port; int cyc; } wd_t;
  beat_t exp_b[$];
  int exp_rv[$];
  wd_t exp_wd[$];
  int n_checks = 0, n_errors = 0, cyc = 0;
  bit chk_en = 1'b0;
  int p_kind[N];
  logic [31:0] p_addr[N];
  int p_beat[N];
  int m_ptr = 0, m_lock = 0, m_rbeat = 0;
  bit m_locked = 1'b0;
  int m_tags[$];
  function automatic logic [63:0] wdata_of(input logic [31:0] a, input int b);
    return {a ^ 32'h5A5A_0000, 32'(b)};
  endfunction
  task automatic step(input int new_pct, input int read_pct, input int ready_pct, input int rv_pct);
    int g;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (p_kind[p] == 0 && $urandom_range(99) < new_pct) begin
        p_kind[p] = ($urandom_range(99) < read_pct) ? 1 : 2;
        p_addr[p] = $urandom & 32'hFFFF_FFE0;
        p_beat[p] = 0;
      end
      req_read[p] = p_kind[p] == 1;
      req_write[p] = p_kind[p] == 2;
      req_addr[p] = p_addr[p];
      req_wdata[p] = wdata_of(p_addr[p], p_beat[p]);
    end
    bmem_ready = $urandom_range(99) < ready_pct;
    bmem_rvalid = m_tags.size() > 0 && $urandom_range(99) < rv_pct;
    g = -1;
    if (m_locked) begin
      if (p_kind[m_lock] == 2) g = m_lock;
    end else
      for (int i = 0; i < N; i++) begin
        int q = (m_ptr + i) % N;
        if (g < 0 && (p_kind[q] == 2 || (p_kind[q] == 1 && m_tags.size() < MO))) g = q;
      end
    if (bmem_rvalid) begin
      exp_rv.push_back(m_tags[0]);
      m_rbeat++;
      if (m_rbeat == BL) begin
        void'(m_tags.pop_front());
        m_rbeat = 0;
      end
    end
    if (g >= 0 && bmem_ready) begin
      exp_b.push_back('{g, p_addr[g], wdata_of(p_addr[g], p_beat[g]), p_kind[g] == 2});
      if (p_kind[g] == 1) begin
        m_tags.push_back(g);
        m_ptr = (g + 1) % N;
        p_kind[g] = 0;
      end else begin
        m_locked = 1'b1;
        m_lock = g;
        p_beat[g]++;
        if (p_beat[g] == BL) begin
          m_locked = 1'b0;
          m_ptr = (g + 1) % N;
          p_kind[g] = 0;
          exp_wd.push_back('{g, cyc + 1});
        end
      end
    end
  endtask
  task automatic check_reset(input string name);
    n_checks++;
    if ({req_ready, req_rvalid, req_wdone, bmem_addr, bmem_read, bmem_write, bmem_wdata,
         fp_ready, fp_rvalid, fp_wdone, fp_addr, fp_read, fp_write, fp_wdata} !== '0) begin
      n_errors++;
      $display("FAIL %s: outputs not zero: ready=%b rvalid=%b wdone=%b addr=%h rd=%b wr=%b wdata=%h fp_ready=%b fp_addr=%h fp_rd=%b",
               name, req_ready, req_rvalid, req_wdone, bmem_addr, bmem_read, bmem_write, bmem_wdata, fp_ready, fp_addr, fp_read);
    end
  endtask
  initial begin
    beat_t e;
    wd_t w;
    int r;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (req_ready != '0 || exp_b.size() > 0) begin
          n_checks++;
          if (exp_b.size() == 0) begin
            n_errors++;
            $display("FAIL grant: unexpected req_ready=%b at cycle %0d", req_ready, cyc);
          end else begin
            e = exp_b.pop_front();
            if (req_ready !== (N'(1) << e.port) || bmem_addr !== e.addr || bmem_write !== e.wr ||
                bmem_read !== !e.wr || (e.wr && bmem_wdata !== e.data)) begin
              n_errors++;
              $display("FAIL grant: cycle %0d got ready=%b addr=%h rd=%b wr=%b wdata=%h, want port %0d addr=%h wr=%b wdata=%h",
                       cyc, req_ready, bmem_addr, bmem_read, bmem_write, bmem_wdata, e.port, e.addr, e.wr, e.data);
            end
          end
        end
        if (req_rvalid != '0 || exp_rv.size() > 0) begin
          n_checks++;
          if (exp_rv.size() == 0) begin
            n_errors++;
            $display("FAIL rvalid: unexpected req_rvalid=%b at cycle %0d", req_rvalid, cyc);
          end else begin
            r = exp_rv.pop_front();
            if (req_rvalid !== (N'(1) << r)) begin
              n_errors++;
              $display("FAIL rvalid: cycle %0d got %b, want port %0d", cyc, req_rvalid, r);
            end
          end
        end
        if (req_wdone != '0 || (exp_wd.size() > 0 && exp_wd[0].cyc <= cyc)) begin
          n_checks++;
          if (exp_wd.size() == 0) begin
            n_errors++;
            $display("FAIL wdone: unexpected req_wdone=%b at cycle %0d", req_wdone, cyc);
          end else begin
            w = exp_wd.pop_front();
            if (req_wdone !== (N'(1) << w.port) || w.cyc != cyc) begin
              n_errors++;
              $display("FAIL wdone: cycle %0d got %b, want port %0d at cycle %0d", cyc, req_wdone, w.port, w.cyc);
            end
          end
        end
      end
    end
  end
  initial begin
    @(negedge rst);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (fp_ready !== (k < MO ? N'(1) : N'(0))) begin
        n_errors++;
        $display("FAIL fixed_prio: cycle %0d got ready=%b, want %b", k, fp_ready, k < MO ? N'(1) : N'(0));
      end
    end
  end
  initial begin
    for (int p = 0; p < N; p++) begin
      p_kind[p] = 0;
      p_addr[p] = '0;
      p_beat[p] = 0;
    end
    req_addr = '0;
    req_wdata = '0;
    req_read = '1;
    req_write = '0;
    bmem_ready = 1'b1;
    bmem_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_read = '0;
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b0;
    chk_en = 1'b1;
    repeat (10) step(100, 100, 100, 0);
    repeat (30) step(100, 100, 100, 100);
    repeat (500) step(60, 20, 80, 60);
    repeat (3000) step(40, 50, 70, 40);
    repeat (80) step(0, 0, 100, 100);
    p_kind[1] = 2;
    p_addr[1] = 32'h0000_1000;
    p_beat[1] = 0;
    repeat (2) step(0, 0, 100, 0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset("reset_midburst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_locked = 1'b0;
    m_ptr = 0;
    m_rbeat = 0;
    m_tags.delete();
    exp_b.delete();
    exp_rv.delete();
    for (int p = 0; p < N; p++) p_kind[p] = 0;
    req_read = '0;
    req_write = '0;
    bmem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_wdone !== '0 || req_ready !== '0) begin
      n_errors++;
      $display("FAIL post_reset: got wdone=%b ready=%b, want 0", req_wdone, req_ready);
    end
    chk_en = 1'b1;
    repeat (4) step(0, 0, 100, 0);
    p_kind[0] = 1;
    p_addr[0] = 32'h0000_2000;
    p_kind[1] = 1;
    p_addr[1] = 32'h0000_3000;
    repeat (3) step(0, 0, 100, 0);
    repeat (12) step(0, 0, 100, 100);
    n_checks++;
    if (exp_wd.size() != 0) begin
      n_errors++;
      $display("FAIL wdone_missing: %0d pulses never seen, want 0", exp_wd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of cache-side requesters (≥2).
REQ-002 SHALL have parameter BURST_LEN, default 4: 64-bit beats per line, for both read responses and write bursts.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: read-tag FIFO depth (power of 2).
REQ-004 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_addr, input, NUM_PORTS x 32: per-port line address.
REQ-008 SHALL have port req_read, input, NUM_PORTS: per-port read request.
REQ-009 SHALL have port req_write, input, NUM_PORTS: per-port write request, held for the whole burst.
REQ-010 SHALL have port req_wdata, input, NUM_PORTS x 64: per-port write beat.
REQ-011 SHALL have port req_ready, output, NUM_PORTS: the current request or beat is accepted this cycle.
REQ-012 SHALL have port req_rvalid, output, NUM_PORTS: bmem_rvalid routed to the owning port.
REQ-013 SHALL have port req_wdone, output, NUM_PORTS: 1-cycle pulse when the port's write burst completes.
REQ-014 SHALL have output ports bmem_addr (32), bmem_read (1), bmem_write (1) and bmem_wdata (64): the downstream request channel.
REQ-015 SHALL have input ports bmem_ready (1) and bmem_rvalid (1): downstream accept and read-beat valid. bmem_raddr and bmem_rdata are broadcast outside this block.

Function
REQ-016 SHALL implement FSM states IDLE and WBURST.
REQ-017 In IDLE, SHALL select one requesting port combinationally; bmem_* SHALL mirror the selected port; all other bmem_read/bmem_write SHALL be 0.
REQ-018 A read SHALL be eligible only while the tag FIFO is not full; a port with only an ineligible read SHALL be skipped.
REQ-019 req_ready[p] SHALL equal bmem_ready AND selected==p AND eligible, with zero latency.
REQ-020 An accepted read SHALL push p into the tag FIFO and stay in IDLE.
REQ-021 An accepted first write beat SHALL latch p and a beat count of 1, and SHALL enter WBURST (if BURST_LEN>1).
REQ-022 In WBURST, SHALL forward only the locked port; each bmem_ready beat SHALL increment the count.
REQ-023 On the accept of beat BURST_LEN, SHALL pulse req_wdone[p] the next cycle and return to IDLE.
REQ-024 A read from the locked port during WBURST is a protocol error; SHALL ignore it.
REQ-025 Each bmem_rvalid beat SHALL assert req_rvalid[FIFO head]; after BURST_LEN beats SHALL pop the head and reset the beat counter.
REQ-026 bmem_rvalid with an empty FIFO SHALL be dropped and SHALL set sticky internal flag err_underflow (simulation assertion).
REQ-027 A push and a pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-028 In round-robin mode, the pointer SHALL be set to (granted+1) mod NUM_PORTS after a read accept or write-burst completion; search starts at the pointer.
REQ-029 In fixed-priority mode, the lowest eligible index SHALL win and the pointer SHALL be unused.

Reset
REQ-030 On rst, SHALL enter IDLE; RR pointer, beat counters, FIFO pointers and occupancy SHALL be 0.
REQ-031 During reset, every output SHALL be 0.
REQ-032 Reset mid-burst or with reads outstanding SHALL discard all state with no wdone or rvalid.

Structure
REQ-033 NUM_PORTS/BURST_LEN defaults and the arb_state_t enum SHALL live in rv32i_types.
REQ-034 SHALL use one sub-module, arb_tag_fifo: a parametrised synchronous FIFO of $clog2(NUM_PORTS)-bit tags.

Verification
REQ-035 Ports 0 and 1 read continuously, RR, bmem_ready=1 -> grants alternate 0,1,0,1; tag FIFO order matches.
REQ-036 Port 1 writes 4 beats while port 0 requests a read -> port 0 is blocked until beat 4; req_wdone[1] pulses once; next grant is port 0.
REQ-037 Four reads with no rvalid, then a fifth read -> the fifth req_ready stays 0; after 4 rvalid beats it is accepted.
REQ-038 Interleaved reads 0,1 with 8 rvalid beats -> beats 1-4 give req_rvalid[0], beats 5-8 give req_rvalid[1].
REQ-039 FIXED_PRIO=1, both ports requesting -> port 0 always wins.
REQ-040 rst asserted at write beat 2 -> IDLE and outputs 0 next cycle; no wdone pulse.
